// File: rtl/muldiv_hilo_if.sv
// Decoder/register-file side bundle for the multiply/divide unit: request strobes,
// operands, and the HI/LO/busy/stall/done results.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
) ();
    logic             mult;
    logic             multu;
    logic             div;
    logic             divu;
    logic             mthi;
    logic             mtlo;
    logic             mfhi;
    logic             mflo;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output mult, multu, div, divu, mthi, mtlo, mfhi, mflo, rs_val, rt_val,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  mult, multu, div, divu, mthi, mtlo, mfhi, mflo, rs_val, rt_val,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Define MULDIV_FAST_MULT_EN to make mult/multu single-cycle (divide stays iterative).
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_hilo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_reg, state_next;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_reg;
    logic               neg_rem_reg;
    logic               dbz_reg;
    logic               done_reg;

    // Request decode with fixed priority mult > multu > div > divu > mthi > mtlo.
    logic             req_mul, req_div, sel_signed, neg_req, any_req, last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign req_mul    = bus.mult | bus.multu;
    assign req_div    = ~req_mul & (bus.div | bus.divu);
    assign sel_signed = bus.mult | (~bus.multu & bus.div);
    assign abs_a      = (sel_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign abs_b      = (sel_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    assign neg_req    = sel_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
    assign any_req    = bus.mult | bus.multu | bus.div | bus.divu |
                        bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
    assign last_iter  = (cnt_reg == CNT_W'(WIDTH - 1));

    // Multiply step: multiplier sits in the low half and shifts out LSB first.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] mul_res;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                      (acc_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
    assign mul_res  = neg_reg ? -mul_step : mul_step;

    // Divide step: upper half is the partial remainder, lower half dividend -> quotient.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_step  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ok};
    // Magnitude division already yields 0x8000_0000 / 0 for the signed overflow case.
    assign quo_res   = dbz_reg ? {WIDTH{1'b1}} :
                       (neg_reg ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0]);
    assign rem_res   = dbz_reg ? a_raw_reg :
                       (neg_rem_reg ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH]);

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    assign fast_prod = neg_req ? -fast_mag : fast_mag;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
`ifdef MULDIV_FAST_MULT_EN
                if (req_div) state_next = DIV;
`else
                if (req_mul)      state_next = MUL;
                else if (req_div) state_next = DIV;
`endif
            end
            MUL:     if (last_iter) state_next = IDLE;
            DIV:     if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            b_reg       <= '0;
            a_raw_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            dbz_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                        hi_reg   <= fast_prod[2*WIDTH-1:WIDTH];
                        lo_reg   <= fast_prod[WIDTH-1:0];
                        done_reg <= 1'b1;
`else
                        acc_reg <= {{WIDTH{1'b0}}, abs_a};
                        b_reg   <= abs_b;
                        neg_reg <= neg_req;
                        cnt_reg <= '0;
`endif
                    end else if (req_div) begin
                        acc_reg     <= {{WIDTH{1'b0}}, abs_a};
                        b_reg       <= abs_b;
                        a_raw_reg   <= bus.rs_val;
                        neg_reg     <= neg_req;
                        neg_rem_reg <= sel_signed & bus.rs_val[WIDTH-1];
                        dbz_reg     <= (bus.rt_val == '0);
                        cnt_reg     <= '0;
                    end else if (bus.mthi) begin
                        hi_reg <= bus.rs_val;
                    end else if (bus.mtlo) begin
                        lo_reg <= bus.rs_val;
                    end
                end
                MUL: begin
                    acc_reg <= mul_step;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi_reg   <= mul_res[2*WIDTH-1:WIDTH];
                        lo_reg   <= mul_res[WIDTH-1:0];
                        done_reg <= 1'b1;
                    end
                end
                DIV: begin
                    acc_reg <= div_step;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi_reg   <= rem_res;
                        lo_reg   <= quo_res;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;
    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = done_reg;
    assign bus.stall = bus.busy & any_req;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: expected HI/LO pairs are queued at request time
// and compared when done pulses.
module tb_muldiv_hilo;
    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(32)) bus ();

    muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint sa, sb, p;
        logic [63:0] up;
        int ia, ib;
        r.hi = '0;
        r.lo = '0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            OP_DIVU: begin
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            default: begin
                ia = a;
                ib = b;
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'h0; r.lo = 32'h8000_0000;
                end else begin r.lo = ia / ib; r.hi = ia % ib; end
            end
        endcase
        return r;
    endfunction

    task automatic clear_req();
        bus.mult = 0; bus.multu = 0; bus.div = 0; bus.divu = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 0; bus.mflo = 0;
    endtask

    // Drives one request at the next falling edge; the DUT samples it on the following rise.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.rs_val = a;
        bus.rt_val = b;
        bus.mult  = (op == OP_MULT);
        bus.multu = (op == OP_MULTU);
        bus.div   = (op == OP_DIV);
        bus.divu  = (op == OP_DIVU);
    endtask

    task automatic wait_done(output int nbusy, output bit tmo);
        nbusy = 0;
        tmo = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) clear_req();
            if (bus.done === 1'b1) begin tmo = 0; break; end
            if (bus.busy === 1'b1) nbusy++;
        end
        if (tmo) $display("FAIL wait_done: got no done pulse, required one within 200 cycles");
    endtask

    task automatic test_reset();
        clear_req();
        bus.rs_val = '0;
        bus.rt_val = '0;
        #2;
        total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h required 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h required 0", bus.lo); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mult();
        int nb; bit tmo; exp_t e;
        exp_t plan[2];
        plan[0].hi = 32'hFFFF_FFFF; plan[0].lo = 32'hFFFF_FFFE;
        plan[1].hi = 32'h0000_0001; plan[1].lo = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(plan[k]);
            issue(k == 0 ? OP_MULT : OP_MULTU, 32'hFFFF_FFFF, 32'h2);
            wait_done(nb, tmo);
            total++; if (tmo) ; else passed++;
            e = sb_q.pop_front();
            $display("%s ffffffff*2 -> hi=%h lo=%h busy_cycles=%0d", k == 0 ? "mult " : "multu", bus.hi, bus.lo, nb);
            total++; if (nb !== 32) $display("FAIL mult_busy_cycles: got %0d required 32", nb); else passed++;
            total++; if (bus.hi !== e.hi) $display("FAIL mult_hi: got %h required %h", bus.hi, e.hi); else passed++;
            total++; if (bus.lo !== e.lo) $display("FAIL mult_lo: got %h required %h", bus.lo, e.lo); else passed++;
            @(negedge clk);
            total++; if (bus.done !== 1'b0) $display("FAIL mult_done_width: got %b required 0", bus.done); else passed++;
        end
    endtask

    task automatic run_div_cases(input string name, input int n, input int ops[4],
                                 input logic [31:0] as[4], input logic [31:0] bs[4]);
        int nb; bit tmo; exp_t e;
        for (int k = 0; k < n; k++) begin
            sb_q.push_back(model(ops[k], as[k], bs[k]));
            issue(ops[k], as[k], bs[k]);
            wait_done(nb, tmo);
            total++; if (tmo) ; else passed++;
            e = sb_q.pop_front();
            $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h", name, ops[k], as[k], bs[k], bus.hi, bus.lo);
            total++; if (bus.hi !== e.hi) $display("FAIL %s_hi: got %h required %h", name, bus.hi, e.hi); else passed++;
            total++; if (bus.lo !== e.lo) $display("FAIL %s_lo: got %h required %h", name, bus.lo, e.lo); else passed++;
        end
    endtask

    task automatic test_div();
        int ops[4] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
        logic [31:0] as[4] = '{32'd100, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] bs[4] = '{32'd7, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        run_div_cases("div", 4, ops, as, bs);
        // Independent spot check of the test-plan constants for the signed case.
        total++; if (model(OP_DIV, 32'hFFFF_FFF9, 32'd2).lo !== 32'hFFFF_FFFD)
            $display("FAIL div_model_lo: got %h required fffffffd", model(OP_DIV, 32'hFFFF_FFF9, 32'd2).lo); else passed++;
    endtask

    task automatic test_div_special();
        int ops[4] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] as[4] = '{32'h1234_5678, 32'h8000_0000, 32'hCAFE_0001, 32'h8765_4321};
        logic [31:0] bs[4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        run_div_cases("div_special", 4, ops, as, bs);
    endtask

    task automatic test_stall();
        int nb = 0; bit seen_done = 0; exp_t e;
        sb_q.push_back(model(OP_MULT, 32'h0000_1234, 32'h0000_0010));
        issue(OP_MULT, 32'h0000_1234, 32'h0000_0010);
        bus.mflo = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) bus.mult = 0;
            if (bus.done === 1'b1) begin
                total++; if (bus.stall !== 1'b0) $display("FAIL stall_done_cycle: got %b required 0", bus.stall); else passed++;
                seen_done = 1;
                break;
            end
            if (bus.busy === 1'b1) begin
                nb++;
                total++; if (bus.stall !== 1'b1) $display("FAIL stall_busy_cycle %0d: got %b required 1", nb, bus.stall); else passed++;
            end
            bus.mtlo   = (i >= 2 && i < 6);
            bus.rs_val = 32'hAAAA_AAAA;
        end
        clear_req();
        total++; if (!seen_done) $display("FAIL stall_timeout: got no done, required done"); else passed++;
        e = sb_q.pop_front();
        $display("stall mult 1234*10 mflo held -> lo=%h busy_cycles=%0d", bus.lo, nb);
        total++; if (bus.lo !== e.lo) $display("FAIL stall_lo: got %h required %h", bus.lo, e.lo); else passed++;
        total++; if (bus.hi !== e.hi) $display("FAIL stall_hi: got %h required %h", bus.hi, e.hi); else passed++;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.rs_val = 32'hDEAD_BEEF; bus.mthi = 1;
        @(negedge clk);
        bus.mthi = 0;
        $display("mthi deadbeef -> hi=%h busy=%b done=%b", bus.hi, bus.busy, bus.done);
        total++; if (bus.hi !== 32'hDEAD_BEEF) $display("FAIL mthi_hi: got %h required deadbeef", bus.hi); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy: got %b required 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL mthi_done: got %b required 0", bus.done); else passed++;
        bus.rs_val = 32'hCAFE_F00D; bus.mtlo = 1;
        @(negedge clk);
        bus.mtlo = 0;
        $display("mtlo cafef00d -> lo=%h hi=%h", bus.lo, bus.hi);
        total++; if (bus.lo !== 32'hCAFE_F00D) $display("FAIL mtlo_lo: got %h required cafef00d", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hDEAD_BEEF) $display("FAIL mtlo_hi_kept: got %h required deadbeef", bus.hi); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL mtlo_done: got %b required 0", bus.done); else passed++;
    endtask

    task automatic test_back_to_back();
        int nb; bit tmo; exp_t e; int op; logic [31:0] a, b;
        for (int k = 0; k < 8; k++) begin
            op = k % 4;
            a  = $urandom;
            b  = (k == 5) ? 32'h0 : $urandom_range(1, 32'h0001_FFFF) * ((k % 3 == 0) ? 32'hFFFF_FFFF : 32'h1);
            sb_q.push_back(model(op, a, b));
            issue(op, a, b);
            wait_done(nb, tmo);
            total++; if (tmo) ; else passed++;
            e = sb_q.pop_front();
            $display("b2b op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
            total++; if (bus.hi !== e.hi) $display("FAIL b2b_hi: got %h required %h", bus.hi, e.hi); else passed++;
            total++; if (bus.lo !== e.lo) $display("FAIL b2b_lo: got %h required %h", bus.lo, e.lo); else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int nb; bit tmo; exp_t e;
        @(negedge clk);
        bus.rs_val = 32'h1111_2222; bus.mthi = 1;
        @(negedge clk);
        bus.mthi = 0; bus.rs_val = 32'h3333_4444; bus.mtlo = 1;
        @(negedge clk);
        bus.mtlo = 0;
        sb_q.push_back(model(OP_DIVU, 32'hFFFF_0000, 32'd3));
        issue(OP_DIVU, 32'hFFFF_0000, 32'd3);
        @(negedge clk);
        clear_req();
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_front());
        $display("abort at iteration 10 -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
        total++; if (bus.hi !== 32'h0) $display("FAIL abort_hi: got %h required 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL abort_lo: got %h required 0", bus.lo); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", bus.busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(model(OP_DIVU, 32'd1000, 32'd10));
        issue(OP_DIVU, 32'd1000, 32'd10);
        wait_done(nb, tmo);
        total++; if (tmo) ; else passed++;
        e = sb_q.pop_front();
        $display("divu after abort 1000/10 -> hi=%h lo=%h busy_cycles=%0d", bus.hi, bus.lo, nb);
        total++; if (bus.lo !== e.lo) $display("FAIL abort_recover_lo: got %h required %h", bus.lo, e.lo); else passed++;
        total++; if (bus.hi !== e.hi) $display("FAIL abort_recover_hi: got %h required %h", bus.hi, e.hi); else passed++;
        total++; if (nb !== 32) $display("FAIL abort_recover_busy: got %0d required 32", nb); else passed++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_stall();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
